// File: rtl/gate_test_pkg.sv
// Shared types and widths for the gate test sequencer and its reference gate.
package gate_test_pkg;

  localparam int IDX_W    = 8;
  localparam int ERR_W    = 16;
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  // Counts up by one but sticks at the all-ones value instead of wrapping.
  function automatic logic [ERR_W-1:0] satInc(input logic [ERR_W-1:0] value);
    return (value == {ERR_W{1'b1}}) ? value : value + ERR_W'(1);
  endfunction

endpackage

// File: rtl/gate_ref_and.sv
// Reference model of the gate under test: a two-input AND.
// Replace this module with another gate to exercise a different device.
module gate_ref_and (
  input  logic a_i,
  input  logic b_i,
  output logic expected_o
);

  assign expected_o = a_i & b_i;

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks a two-input gate through NUM_VECTORS patterns, waits SETTLE cycles
// for each, and compares both device outputs against the reference gate,
// accumulating an error count, a sticky mismatch mask and the first bad index.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int NUM_VECTORS = 16,
  parameter int SETTLE      = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  input  logic             out_assign_dut,
  input  logic             out_alwaysblock_dut,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] pattern_idx,
  output logic [ERR_W-1:0] error_count,
  output logic [1:0]       mismatch_mask,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             first_err_valid
);

  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  state_e              state_q;
  logic                a_q;
  logic                b_q;
  logic                busy_q;
  logic                done_q;
  logic [IDX_W-1:0]    patternIdx_q;
  logic [ERR_W-1:0]    errorCount_q;
  logic [ERR_W-1:0]    errorCount_d;
  logic [1:0]          mismatchMask_q;
  logic [IDX_W-1:0]    firstErrIdx_q;
  logic                firstErrValid_q;
  logic [SETTLE_W-1:0] settleCnt_q;
  logic                expected;
  logic [1:0]          mismatch;

  gate_ref_and uRef (
    .a_i        (a_q),
    .b_i        (b_q),
    .expected_o (expected)
  );

  // Per-output mismatch against the reference and the saturated next error count.
  always_comb begin
    mismatch     = {out_assign_dut != expected, out_alwaysblock_dut != expected};
    errorCount_d = satInc(errorCount_q);
  end

  // Sequencer FSM; every output is a register updated together with the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      a_q             <= 1'b0;
      b_q             <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      patternIdx_q    <= '0;
      errorCount_q    <= '0;
      mismatchMask_q  <= '0;
      firstErrIdx_q   <= '0;
      firstErrValid_q <= 1'b0;
      settleCnt_q     <= '0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q     <= S_IDLE;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      settleCnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            patternIdx_q    <= '0;
            errorCount_q    <= '0;
            mismatchMask_q  <= '0;
            firstErrIdx_q   <= '0;
            firstErrValid_q <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= S_APPLY;
          end
        end
        S_APPLY: begin
          a_q         <= patternIdx_q[1];
          b_q         <= patternIdx_q[0];
          settleCnt_q <= '0;
          state_q     <= (SETTLE == 0) ? S_CHECK : S_SETTLE;
        end
        S_SETTLE: begin
          if (settleCnt_q == SETTLE_LAST) begin
            state_q <= S_CHECK;
          end else begin
            settleCnt_q <= settleCnt_q + SETTLE_W'(1);
          end
        end
        S_CHECK: begin
          if (|mismatch) begin
            errorCount_q   <= errorCount_d;
            mismatchMask_q <= mismatchMask_q | mismatch;
            if (!firstErrValid_q) begin
              firstErrValid_q <= 1'b1;
              firstErrIdx_q   <= patternIdx_q;
            end
          end
          if (patternIdx_q == LAST_IDX) begin
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            patternIdx_q <= patternIdx_q + IDX_W'(1);
            state_q      <= S_APPLY;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a               = a_q;
  assign b               = b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pattern_idx     = patternIdx_q;
  assign error_count     = errorCount_q;
  assign mismatch_mask   = mismatchMask_q;
  assign first_err_idx   = firstErrIdx_q;
  assign first_err_valid = firstErrValid_q;

endmodule
